i_ram_loader: RTL
=================

I_RAM_LOADER -- requirements
Module: i_ram_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: width of the instruction-RAM word address.
REQ-002 Parameter DATA_WIDTH, default 16: instruction word width, fixed at 16 (two bytes per word).
REQ-003 Parameter TIMEOUT, default 1000000: maximum idle clk cycles allowed between bytes of an active load.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 rx_data  input  8  received byte from the UART receiver.
REQ-007 rx_valid  input  1  rx_data holds a byte; a byte is accepted on any cycle where rx_valid and rx_ready are both high.
REQ-008 rx_ready  output  1  loader can accept a byte this cycle.
REQ-009 ram_w_addr  output  ADDR_WIDTH  instruction-RAM write address.
REQ-010 ram_din  output  DATA_WIDTH  instruction-RAM write data.
REQ-011 ram_w_en  output  1  instruction-RAM write strobe, one cycle per word.
REQ-012 cpu_rst_n  output  1  low holds the CPU in reset; high releases it.
REQ-013 busy  output  1  high while a load is in progress (any state from CNT_HI through CHECK).
REQ-014 done  output  1  high in state DONE.
REQ-015 err  output  1  high in state ERR.

Function
REQ-016 Frame format: sync byte 0xA5, then count N (16 bits, high byte first), then 2N data bytes (each word high byte first), then one checksum byte.
REQ-017 The checksum SHALL be the modulo-256 sum of the 2N data bytes only.
REQ-018 The FSM SHALL have states IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE and ERR.
REQ-019 IDLE: an accepted 0xA5 moves to CNT_HI; any other accepted byte is discarded with no state change.
REQ-020 CNT_HI -> CNT_LO on an accepted byte.
REQ-021 CNT_LO: on an accepted byte, N > 2^ADDR_WIDTH -> ERR; N == 0 -> CHECK; otherwise -> DATA_HI with the word address cleared to 0.
REQ-022 DATA_HI: latches the high byte and goes to DATA_LO. DATA_LO: latches the low byte and goes to WRITE.
REQ-023 WRITE lasts exactly one cycle, with ram_w_en=1, ram_din={hi,lo} and ram_w_addr equal to the current word index; ram_w_en SHALL be high only in WRITE.
REQ-024 ram_w_en SHALL assert in the cycle immediately after the low byte is accepted.
REQ-025 On leaving WRITE the word index increments; index == N-1 -> CHECK, otherwise -> DATA_HI.
REQ-026 The address SHALL never wrap: index N-1 = 2^ADDR_WIDTH-1 is the final write.
REQ-027 CHECK: an accepted byte equal to the running sum -> DONE; any other byte -> ERR.
REQ-028 rx_ready SHALL be 1 in every state except WRITE, where it is 0.
REQ-029 The running sum and the idle counter SHALL clear on entry to CNT_HI.
REQ-030 Timeout: in CNT_HI, CNT_LO, DATA_HI, DATA_LO or CHECK, reaching TIMEOUT consecutive cycles with no accepted byte -> ERR.
REQ-031 The idle counter SHALL reset on every accepted byte and SHALL saturate, never wrap.
REQ-032 DONE and ERR: an accepted 0xA5 restarts at CNT_HI (cpu_rst_n driven low again and done/err clear); all other bytes are discarded.
REQ-033 cpu_rst_n SHALL be 1 only in DONE.
REQ-034 Outputs SHALL be registered; no combinational path from rx_* to ram_* outputs.

Reset
REQ-035 When rst_n goes low, at any time including mid-load, the FSM SHALL go to IDLE without waiting for clk.
REQ-036 Reset values: ram_w_en=0, ram_w_addr=0, ram_din=0, cpu_rst_n=0, busy=0, done=0, err=0, rx_ready=1, sum=0, idle counter=0.
REQ-037 A load interrupted by reset SHALL produce no further RAM writes; after reset the block waits for a fresh 0xA5.

Verification
REQ-038 Bytes A5 00 02 12 34 AB CD BE -> exactly two writes (addr0=0x1234, addr1=0xABCD), each one cycle after its low byte; then done=1, cpu_rst_n=1.
REQ-039 Same frame with checksum 0xBF -> both writes occur, then err=1 and cpu_rst_n=0.
REQ-040 Bytes 00 FF 13 then A5 00 00 00 -> leading garbage ignored; no writes; done=1.
REQ-041 With ADDR_WIDTH=4: A5 00 11 -> err=1 with no writes. A5 00 10 plus 16 words -> last write to addr 0xF; no address wrap.
REQ-042 TIMEOUT=100: A5 00 01 12, then silence -> err=1 exactly 100 cycles after byte 0x12 was accepted.
REQ-043 rst_n pulsed low between the high and low data bytes -> outputs take reset values immediately; no ram_w_en; a following complete frame loads correctly.

Source files
------------

// File: rtl/i_ram_loader.sv
// i_ram_loader: receives a framed program over a UART byte stream,
// writes it into instruction RAM and holds the CPU in reset until done.
module i_ram_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_w_en,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_WIDTH;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO,
    WRITE, CHECK, DONE, ERR
  } state_t;

  state_t state, state_nxt;

  logic                  acc;
  logic                  timed;
  logic                  tmo;
  logic                  last;
  logic                  start;
  logic [16:0]           n_now;
  logic [7:0]            cnt_hi;
  logic [15:0]           n;
  logic [7:0]            hi;
  logic [7:0]            sum;
  logic [ADDR_WIDTH-1:0] idx;
  logic [CW-1:0]         idle;

  logic wen_nxt;
  logic ready_nxt;
  logic busy_nxt;
  logic done_nxt;
  logic err_nxt;
  logic cpu_nxt;

  assign acc   = rx_valid & rx_ready;
  assign n_now = {1'b0, cnt_hi, rx_data};
  assign last  = (17'(idx) == ({1'b0, n} - 17'd1));
  assign timed = state inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK};
  assign tmo   = timed & ~acc & (idle == TMO_LAST);
  assign start = (state_nxt == CNT_HI) & (state != CNT_HI);

  assign ram_w_addr = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE, ERR:
        if (acc && rx_data == SYNC) state_nxt = CNT_HI;
      CNT_HI:
        if (acc) state_nxt = CNT_LO;
      CNT_LO:
        if (acc) begin
          if (n_now > MAX_N)       state_nxt = ERR;
          else if (n_now == 17'd0) state_nxt = CHECK;
          else                     state_nxt = DATA_HI;
        end
      DATA_HI:
        if (acc) state_nxt = DATA_LO;
      DATA_LO:
        if (acc) state_nxt = WRITE;
      WRITE:
        state_nxt = last ? CHECK : DATA_HI;
      CHECK:
        if (acc) state_nxt = (rx_data == sum) ? DONE : ERR;
      default:
        state_nxt = IDLE;
    endcase
    if (tmo) state_nxt = ERR;
  end

  // Outputs are decoded from the next state and registered below.
  always_comb begin
    wen_nxt   = (state_nxt == WRITE);
    ready_nxt = (state_nxt != WRITE);
    busy_nxt  = state_nxt inside
      {CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHECK};
    done_nxt  = (state_nxt == DONE);
    err_nxt   = (state_nxt == ERR);
    cpu_nxt   = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_w_en  <= 1'b0;
      rx_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      ram_w_en  <= wen_nxt;
      rx_ready  <= ready_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      cpu_rst_n <= cpu_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_hi  <= '0;
      n       <= '0;
      hi      <= '0;
      sum     <= '0;
      idx     <= '0;
      idle    <= '0;
      ram_din <= '0;
    end else begin
      if (start) begin
        sum  <= '0;
        idle <= '0;
      end else if (acc || state == WRITE) begin
        idle <= '0;
      end else if (timed && idle != TMO) begin
        idle <= idle + CW'(1);
      end
      case (state)
        CNT_HI:
          if (acc) cnt_hi <= rx_data;
        CNT_LO:
          if (acc) begin
            n   <= n_now[15:0];
            idx <= '0;
          end
        DATA_HI:
          if (acc) begin
            hi  <= rx_data;
            sum <= sum + rx_data;
          end
        DATA_LO:
          if (acc) begin
            ram_din <= DATA_WIDTH'({hi, rx_data});
            sum     <= sum + rx_data;
          end
        // Holding the index on the final word keeps it from wrapping.
        WRITE:
          if (!last) idx <= idx + ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule
